// File: rtl/timer_counter_pkg.sv
// Shared definitions for the CPU timer: register indices, CTRL layout, mode codes and FSM states.
// CTRL layout matches the architectural view: IM[3], Mode[2:1], Enable[0].
package timer_counter_pkg;

  typedef enum logic [1:0] {
    IDX_CTRL   = 2'd0,
    IDX_PRESET = 2'd1,
    IDX_COUNT  = 2'd2,
    IDX_RSVD   = 2'd3
  } reg_idx_t;

  // Codes 10/11 are not decoded separately; anything but auto-reload acts as one-shot.
  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'b00,
    MODE_RELOAD  = 2'b01,
    MODE_RSVD2   = 2'b10,
    MODE_RSVD3   = 2'b11
  } mode_t;

  typedef struct packed {
    logic  im;
    mode_t mode;
    logic  enable;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counter timer with one-shot/auto-reload modes; irq_flag rises N+2 edges after Enable.
// Register writes take effect on the next edge; rdata is combinational; no backpressure (bus always accepted).
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] rdata,
  output logic        irq
);

  state_t      state, state_nxt;
  ctrl_t       ctrl, ctrl_nxt;
  logic [31:0] preset;
  logic [31:0] count, count_nxt;
  logic        irq_flag, irq_flag_nxt;
  logic        wr_en, ctrl_wr, preset_wr;

  assign wr_en     = sel && (byteen == 4'b1111);
  assign ctrl_wr   = wr_en && (reg_idx_t'(addr) == IDX_CTRL);
  assign preset_wr = wr_en && (reg_idx_t'(addr) == IDX_PRESET);

  always_comb begin
    state_nxt    = state;
    ctrl_nxt     = ctrl;
    count_nxt    = count;
    irq_flag_nxt = irq_flag;
    case (state)
      ST_IDLE: begin
        if (ctrl.enable) begin
          irq_flag_nxt = 1'b0;
          state_nxt    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_nxt = preset;
        state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl.enable) begin
          state_nxt = ST_IDLE;
        end else if (count > 32'd1) begin
          count_nxt = count - 32'd1;
        end else begin
          // COUNT of 0 or 1 both terminate here, so a zero preset never wraps.
          count_nxt    = 32'd0;
          irq_flag_nxt = 1'b1;
          state_nxt    = ST_INT;
        end
      end
      ST_INT: begin
        state_nxt = ST_IDLE;
        if (ctrl.mode == MODE_RELOAD) irq_flag_nxt = 1'b0;
        else                          ctrl_nxt.enable = 1'b0;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Software CTRL writes override the FSM's own Enable clear and always drop the flag.
    if (ctrl_wr) begin
      ctrl_nxt     = ctrl_t'(wdata[3:0]);
      irq_flag_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      ctrl     <= ctrl_nxt;
      count    <= count_nxt;
      irq_flag <= irq_flag_nxt;
      if (preset_wr) preset <= wdata;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (reg_idx_t'(addr))
      IDX_CTRL:   rdata = {28'd0, ctrl};
      IDX_PRESET: rdata = preset;
      IDX_COUNT:  rdata = count;
      default:    rdata = 32'd0;
    endcase
  end

  assign irq = ctrl.im & irq_flag;

endmodule

// File: tb/tb_timer_counter.sv
// Scenario bench for timer_counter: expected per-edge COUNT/irq pushed to a scoreboard queue and popped as edges occur.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic [31:0] rdata;
  logic        irq;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [31:0] count;
    logic        irq;
    bit          chk_cnt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  timer_counter dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .addr   (addr),
    .wdata  (wdata),
    .byteen (byteen),
    .rdata  (rdata),
    .irq    (irq)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    sel = 1'b1; addr = a; wdata = d; byteen = be;
    @(posedge clk);
    #1;
    sel = 1'b0; byteen = 4'b0000; wdata = 32'd0; addr = 2'd2;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  function automatic exp_t mk(input logic [31:0] c, input logic i, input bit chk);
    exp_t e;
    e.count = c; e.irq = i; e.chk_cnt = chk;
    return e;
  endfunction

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b0; sel = 1'b0; addr = 2'd0; wdata = 32'd0; byteen = 4'b0000;
    #2;
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], v);
      tests++;
      if (v !== 32'd0) begin
        failed++; $display("FAIL reset_rdata idx %0d: got %h want 0", a, v);
      end
    end
    tests++;
    if (irq !== 1'b0) begin failed++; $display("FAIL reset_irq: got %b want 0", irq); end
    @(negedge clk);
    reset = 1'b1;
    tick(3);
    rd(2'd2, v);
    tests++;
    if (v !== 32'd0) begin failed++; $display("FAIL reset_idle_count: got %0d want 0", v); end
  endtask

  task automatic test_oneshot;
    logic [31:0] v;
    exp_t e;
    int k;
    bus_write(2'd1, 32'd5, 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);
    sb.push_back(mk(0, 0, 1)); sb.push_back(mk(5, 0, 1)); sb.push_back(mk(4, 0, 1));
    sb.push_back(mk(3, 0, 1)); sb.push_back(mk(2, 0, 1)); sb.push_back(mk(1, 0, 1));
    sb.push_back(mk(0, 1, 1)); sb.push_back(mk(0, 1, 1)); sb.push_back(mk(0, 1, 1));
    k = 0;
    while (sb.size() > 0) begin
      tick(1); k++;
      e = sb.pop_front();
      rd(2'd2, v);
      if (e.chk_cnt) begin
        tests++;
        if (v !== e.count) begin failed++; $display("FAIL oneshot_count edge %0d: got %0d want %0d", k, v, e.count); end
      end
      tests++;
      if (irq !== e.irq) begin failed++; $display("FAIL oneshot_irq edge %0d: got %b want %b", k, irq, e.irq); end
    end
    rd(2'd0, v);
    tests++;
    if (v !== 32'h8) begin failed++; $display("FAIL oneshot_ctrl: got %h want 8", v); end
  endtask

  task automatic test_irq_clear;
    logic [31:0] v;
    tests++;
    if (irq !== 1'b1) begin failed++; $display("FAIL clear_pre_irq: got %b want 1", irq); end
    bus_write(2'd0, 32'h8, 4'hF);
    tests++;
    if (irq !== 1'b0) begin failed++; $display("FAIL clear_irq: got %b want 0", irq); end
    bus_write(2'd1, 32'h1234, 4'b0011);
    rd(2'd1, v);
    tests++;
    if (v !== 32'd5) begin failed++; $display("FAIL partial_preset: got %h want 5", v); end
  endtask

  task automatic test_reload;
    logic [31:0] v;
    exp_t e;
    int k;
    bus_write(2'd1, 32'd3, 4'hF);
    bus_write(2'd0, 32'hB, 4'hF);
    for (int i = 1; i <= 20; i++) sb.push_back(mk(0, (i % 6) == 5, 0));
    k = 0;
    while (sb.size() > 0) begin
      tick(1); k++;
      e = sb.pop_front();
      tests++;
      if (irq !== e.irq) begin failed++; $display("FAIL reload_irq edge %0d: got %b want %b", k, irq, e.irq); end
    end
    // Edge 20 leaves COUNT=3 in CNT; the stop write decrements once more, then it freezes.
    bus_write(2'd0, 32'h0, 4'hF);
    for (int i = 0; i < 6; i++) sb.push_back(mk(2, 0, 1));
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd(2'd2, v);
      tests++;
      if (v !== e.count || irq !== e.irq) begin
        failed++; $display("FAIL reload_stop step %0d: got count %0d irq %b want %0d %b", k, v, irq, e.count, e.irq);
      end
      tick(1); k++;
    end
  endtask

  task automatic test_pause;
    logic [31:0] v;
    exp_t e;
    int k;
    bus_write(2'd1, 32'd20, 4'hF);
    bus_write(2'd0, 32'h1, 4'hF);
    tick(4);
    bus_write(2'd1, 32'd50, 4'hF);
    rd(2'd2, v);
    tests++;
    if (v !== 32'd17) begin failed++; $display("FAIL preset_during_cnt: got %0d want 17", v); end
    tick(6);
    rd(2'd2, v);
    tests++;
    if (v !== 32'd11) begin failed++; $display("FAIL pause_pre: got %0d want 11", v); end
    bus_write(2'd0, 32'h0, 4'hF);
    for (int i = 0; i < 4; i++) sb.push_back(mk(10, 0, 1));
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd(2'd2, v);
      tests++;
      if (v !== e.count || irq !== e.irq) begin
        failed++; $display("FAIL pause_hold step %0d: got count %0d irq %b want %0d %b", k, v, irq, e.count, e.irq);
      end
      tick(1); k++;
    end
    bus_write(2'd0, 32'h1, 4'hF);
    tick(1);
    rd(2'd2, v);
    tests++;
    if (v !== 32'd10) begin failed++; $display("FAIL resume_idle: got %0d want 10", v); end
    tick(1);
    rd(2'd2, v);
    tests++;
    if (v !== 32'd50) begin failed++; $display("FAIL resume_load: got %0d want 50", v); end
    bus_write(2'd0, 32'h0, 4'hF);
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    bus_write(2'd1, 32'd30, 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);
    tick(25);
    rd(2'd2, v);
    tests++;
    if (v !== 32'd7) begin failed++; $display("FAIL rstmid_pre: got %0d want 7", v); end
    #1;
    reset = 1'b0;
    #1;
    v = rdata;
    tests++;
    if (v !== 32'd0 || irq !== 1'b0) begin
      failed++; $display("FAIL rstmid_async: got count %0d irq %b want 0 0", v, irq);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick(4);
    rd(2'd2, v);
    tests++;
    if (v !== 32'd0) begin failed++; $display("FAIL rstmid_idle_count: got %0d want 0", v); end
    rd(2'd0, v);
    tests++;
    if (v !== 32'd0) begin failed++; $display("FAIL rstmid_ctrl: got %h want 0", v); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    exp_t e;
    int k;
    bus_write(2'd1, 32'd0, 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);
    sb.push_back(mk(0, 0, 1)); sb.push_back(mk(0, 0, 1)); sb.push_back(mk(0, 1, 1));
    k = 0;
    while (sb.size() > 0) begin
      tick(1); k++;
      e = sb.pop_front();
      rd(2'd2, v);
      tests++;
      if (v !== e.count || irq !== e.irq) begin
        failed++; $display("FAIL zero_preset edge %0d: got count %0d irq %b want %0d %b", k, v, irq, e.count, e.irq);
      end
    end
    rd(2'd3, v);
    tests++;
    if (v !== 32'd0) begin failed++; $display("FAIL idx3_read: got %h want 0", v); end
    // This write lands on the INT edge, where the FSM would otherwise clear Enable.
    bus_write(2'd0, 32'h9, 4'hF);
    rd(2'd0, v);
    tests++;
    if (v !== 32'h9 || irq !== 1'b0) begin
      failed++; $display("FAIL ctrl_wins: got ctrl %h irq %b want 9 0", v, irq);
    end
    tick(3);
    tests++;
    if (irq !== 1'b1) begin failed++; $display("FAIL restart_irq: got %b want 1", irq); end
    bus_write(2'd3, 32'hFFFF_FFFF, 4'hF);
    rd(2'd3, v);
    tests++;
    if (v !== 32'd0) begin failed++; $display("FAIL idx3_write: got %h want 0", v); end
    bus_write(2'd2, 32'h55, 4'hF);
    rd(2'd2, v);
    tests++;
    if (v !== 32'd0) begin failed++; $display("FAIL count_write: got %h want 0", v); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_oneshot();
    test_irq_clear();
    test_reload();
    test_pause();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 The module SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock shared with the CPU.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-004 sel  input  1  chip select, already decoded by the system bridge from m_data_addr.
REQ-005 addr  input  2  register index (m_data_addr[3:2]): 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved.
REQ-006 wdata  input  32  store data (m_data_wdata).
REQ-007 byteen  input  4  store byte enables (m_data_byteen).
REQ-008 rdata  output  32  read data for the bridge; combinational from addr.
REQ-009 irq  output  1  interrupt request; drives one HWInt bit of the CPU.

Function
REQ-010 A register write SHALL occur only when sel=1 and byteen=4'b1111; partial-byte stores are ignored.
REQ-011 CTRL SHALL hold Enable[0], Mode[2:1] (00 one-shot, 01 auto-reload, 10/11 treated as one-shot) and IM[3]; bits 31:4 read 0 and ignore writes.
REQ-012 PRESET SHALL be a full 32-bit read/write register.
REQ-013 COUNT SHALL be read-only; writes to COUNT or index 3 are ignored, and index 3 reads 0.
REQ-014 rdata SHALL be driven with the addressed register regardless of sel, with zero added latency.
REQ-015 The FSM SHALL have the states IDLE, LOAD, CNT and INT, with transitions on each clk edge.
REQ-016 IDLE: if Enable=1 then irq_flag<=0 and go to LOAD; otherwise stay in IDLE.
REQ-017 LOAD: COUNT<=PRESET; go to CNT.
REQ-018 CNT, Enable=0: go to IDLE with COUNT frozen and irq_flag unchanged.
REQ-019 CNT, Enable=1 and COUNT>1: COUNT<=COUNT-1.
REQ-020 CNT, Enable=1 and COUNT<=1: COUNT<=0, irq_flag<=1, go to INT.
REQ-021 INT in one-shot mode: Enable<=0, go to IDLE, irq_flag held.
REQ-022 INT in auto-reload mode: irq_flag<=0, go to IDLE; the next IDLE cycle restarts the timer, giving a one-cycle irq pulse per period.
REQ-023 irq SHALL equal IM & irq_flag.
REQ-024 Any CTRL write SHALL clear irq_flag.
REQ-025 A CTRL write in the same edge as an FSM Enable clear SHALL win, so the software value is stored.
REQ-026 A PRESET write during CNT SHALL NOT change COUNT until the next LOAD.
REQ-027 PRESET=0 SHALL behave as PRESET=1, raising irq_flag on the first CNT edge.
REQ-028 Latency: with PRESET=N>=1, irq_flag rises at the (N+2)th edge after the edge that writes Enable=1.
REQ-029 COUNT arithmetic SHALL be unsigned 32-bit and SHALL never wrap below 0.

Reset
REQ-030 While reset=0, state SHALL be IDLE and CTRL, PRESET, COUNT and irq_flag SHALL be 0, so irq=0 and rdata=0 for index 0.
REQ-031 Reset asserted mid-count SHALL abort the count immediately; after release the timer stays in IDLE until Enable is written.

Structure
REQ-032 The FSM state encodings, register indices, CTRL bit positions and Mode codes SHALL live in the shared definitions file used by the CPU pipeline.
REQ-033 The block SHALL be a single module with no sub-module; the register file and FSM are too small to justify a split.

Verification
REQ-034 PRESET=5, then CTRL=4'b1001 -> COUNT reads 5,4,3,2,1,0; irq rises at the 7th edge after the CTRL write, stays high, and CTRL reads 4'b1000.
REQ-035 PRESET=3, CTRL=4'b1011 -> irq pulses high for exactly 1 cycle every 6 cycles, repeating until Enable is cleared.
REQ-036 With a count in progress at COUNT=10, write CTRL=0 -> COUNT holds 10 and irq stays 0; then write CTRL=1 -> LOAD reloads PRESET.
REQ-037 One-shot irq high, then write CTRL=4'b1000 -> irq drops on the next edge; a byteen=4'b0011 write to PRESET leaves PRESET unchanged.
REQ-038 Pull reset low mid-count (COUNT=7) asynchronously between edges -> irq=0 and COUNT=0 immediately; state is IDLE after release.
REQ-039 Write PRESET=0 with CTRL=4'b1001 -> irq rises at the 3rd edge after the write; index 3 reads 0.
